// File: rtl/fixed_point_logit_bisect.sv
// Inverse of the PWL fixed-point sigmoid: bit-serial bisection finds the largest
// signed x whose sigmoid_pwl(x) does not exceed the (clamped) target probability.

module fixed_point_sigmoid #(
    parameter int DATA_WIDTH = 32,
    parameter int FRACTION   = 22
) (
    input  logic                  sigmoid_enable,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << FRACTION;
    localparam logic [DATA_WIDTH-1:0] C0  = ONE >> 1;
    localparam logic [DATA_WIDTH-1:0] C2  = (ONE >> 1) + (ONE >> 3);
    localparam logic [DATA_WIDTH-1:0] BP2 = (ONE << 1) + (ONE >> 2) + (ONE >> 3);
    // Outer intercept (217/256) makes the segments meet exactly at 2.375.
    localparam logic [DATA_WIDTH-1:0] C3  = (ONE >> 1) + (ONE >> 2) + (ONE >> 4)
                                          + (ONE >> 5) + (ONE >> 8);

    logic                  neg_s;
    logic [DATA_WIDTH-1:0] abs_s;
    logic [DATA_WIDTH-1:0] seg3_s;
    logic [DATA_WIDTH-1:0] f_s;
    logic [DATA_WIDTH-1:0] s_s;

    // Odd-symmetric PWL curve on |x|, mirrored as ONE - f for negative x.
    always_comb begin
        neg_s  = x[DATA_WIDTH-1];
        abs_s  = neg_s ? (~x + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : x;
        seg3_s = (abs_s >> 5) + C3;
        if (abs_s < ONE) begin
            f_s = (abs_s >> 2) + C0;
        end else if (abs_s < BP2) begin
            f_s = (abs_s >> 3) + C2;
        end else if (seg3_s > ONE) begin
            f_s = ONE;
        end else begin
            f_s = seg3_s;
        end
        s_s = neg_s ? (ONE - f_s) : f_s;
        y   = sigmoid_enable ? s_s : x;
    end
endmodule

module fixed_point_logit_bisect #(
    parameter int DATA_WIDTH = 32,
    parameter int INTEGER    = 10,
    parameter int FRACTION   = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  logit_enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic                  out_sat_lo,
    output logic                  out_sat_hi
);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << FRACTION;
    localparam logic [DATA_WIDTH-1:0] MSB = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    if (INTEGER + FRACTION != DATA_WIDTH) begin : g_bad_format
        $error("INTEGER + FRACTION must equal DATA_WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [IW-1:0]         i_q, i_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [DATA_WIDTH-1:0] out_x_q, out_x_d;
    logic                  sat_lo_q, sat_lo_d;
    logic                  sat_hi_q, sat_hi_d;
    logic                  lo_pend_q, lo_pend_d;

    logic [DATA_WIDTH-1:0] clamp_s;
    logic [DATA_WIDTH-1:0] cand_s;
    logic [DATA_WIDTH-1:0] sig_x_s;
    logic [DATA_WIDTH-1:0] sig_y_s;
    logic                  le_s;

    // Outside SEARCH the forward model evaluates sigmoid_pwl(min) for the low-saturation test.
    always_comb begin
        if ($signed(in_y) < $signed({DATA_WIDTH{1'b0}})) begin
            clamp_s = {DATA_WIDTH{1'b0}};
        end else if ($signed(in_y) > $signed(ONE)) begin
            clamp_s = ONE;
        end else begin
            clamp_s = in_y;
        end
        cand_s  = r_q | ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << i_q);
        sig_x_s = (state_q == S_SEARCH) ? (cand_s ^ MSB) : MSB;
        le_s    = $signed(sig_y_s) <= $signed(target_q);
    end

    fixed_point_sigmoid #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRACTION   (FRACTION)
    ) u_sigmoid (
        .sigmoid_enable (1'b1),
        .x              (sig_x_s),
        .y              (sig_y_s)
    );

    // Next-state and datapath updates for the accept / search / hold sequence.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        i_d       = i_q;
        target_d  = target_q;
        out_x_d   = out_x_q;
        sat_lo_d  = sat_lo_q;
        sat_hi_d  = sat_hi_q;
        lo_pend_d = lo_pend_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && logit_enable) begin
                    target_d  = clamp_s;
                    lo_pend_d = $signed(sig_y_s) > $signed(clamp_s);
                    r_d       = {DATA_WIDTH{1'b0}};
                    i_d       = IW'(DATA_WIDTH - 1);
                    state_d   = S_SEARCH;
                end else if (in_valid) begin
                    out_x_d  = in_y;
                    sat_lo_d = 1'b0;
                    sat_hi_d = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                r_d = le_s ? cand_s : r_q;
                if (i_q == {IW{1'b0}}) begin
                    out_x_d  = r_d ^ MSB;
                    sat_hi_d = &r_d;
                    sat_lo_d = (r_d == {DATA_WIDTH{1'b0}}) && lo_pend_q;
                    state_d  = S_DONE;
                end else begin
                    i_d = i_q - {{(IW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            r_q       <= {DATA_WIDTH{1'b0}};
            i_q       <= {IW{1'b0}};
            target_q  <= {DATA_WIDTH{1'b0}};
            out_x_q   <= {DATA_WIDTH{1'b0}};
            sat_lo_q  <= 1'b0;
            sat_hi_q  <= 1'b0;
            lo_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            i_q       <= i_d;
            target_q  <= target_d;
            out_x_q   <= out_x_d;
            sat_lo_q  <= sat_lo_d;
            sat_hi_q  <= sat_hi_d;
            lo_pend_q <= lo_pend_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_x      = out_x_q;
    assign out_sat_lo = sat_lo_q;
    assign out_sat_hi = sat_hi_q;
endmodule

// File: doc/fixed_point_logit_bisect.md
Name: fixed_point_logit_bisect

Overview:
- Sequential inverse of the team's PWL fixed-point sigmoid: given a probability y in signed Q(INTEGER).(FRACTION), it returns x such that sigmoid_pwl(x) ≈ y.
- Uses one fixed_point_sigmoid instance (sigmoid_enable tied high) as the forward model and runs a bit-serial bisection, resolving one result bit per cycle.
- Sits after sigmoid activations in the datapath, for recovering pre-activation values and for calibration.
- valid/ready on input and output.

Parameters:
DATA_WIDTH, 32, total word width (two's complement)
INTEGER, 10, integer bits including sign
FRACTION, 22, fraction bits; INTEGER+FRACTION must equal DATA_WIDTH

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
logit_enable  input  1  sampled with in_valid; 0 = bypass (result = in_y)
in_valid  input  1  input word valid
in_ready  output  1  block can accept (high only in IDLE)
in_y  input  DATA_WIDTH  target probability, Q(INTEGER).(FRACTION)
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  downstream accepts result
out_x  output  DATA_WIDTH  result x, Q(INTEGER).(FRACTION)
out_sat_lo  output  1  sigmoid_pwl(min) > y; out_x = most-negative value
out_sat_hi  output  1  out_x = most-positive value (sigmoid_pwl(max) <= y)

Behaviour:
- Reset: synchronous, active-high, highest priority, including mid-search.
  - Next edge: state=IDLE, out_valid=0, out_x=0, both sat flags 0, in_ready=1 on the following cycle.
  - Any in-flight search is discarded.
- States: IDLE, SEARCH, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready, latch logit_enable and the clamped target.
  - Clamp: in_y negative → 0; in_y > ONE, where ONE = 1<<FRACTION, → ONE.
  - logit_enable=1: clear the offset-binary accumulator r, set bit index i=DATA_WIDTH-1, go to SEARCH.
  - logit_enable=0: load out_x=in_y (unclamped), clear flags, go to DONE.
- SEARCH: one bit per cycle, i from DATA_WIDTH-1 down to 0.
  - cand = r | (1<<i).
  - xs = cand with MSB inverted (offset-binary to two's complement).
  - If sigmoid_pwl(xs) <= target, signed compare, then r[i] is set; otherwise r[i] is cleared.
  - After i=0: out_x = r with MSB inverted, go to DONE.
  - Exactly DATA_WIDTH cycles in SEARCH.
  - The sigmoid instance is combinational inside the cycle; no pipelining of the compare.
- Result definition: out_x is the largest signed x with sigmoid_pwl(x) <= target. This requires sigmoid_pwl to be monotonic non-decreasing.
- Flags at SEARCH exit:
  - out_sat_lo=1 iff r==0 and sigmoid_pwl(min) > target.
  - out_sat_hi=1 iff r is all ones.
- DONE: out_valid=1. out_x and flags stay stable while out_valid & !out_ready.
  - On out_ready, go to IDLE the next cycle; out_valid drops.
  - out_ready asserted before out_valid has no effect.
- Latency, acceptance edge to out_valid high:
  - enabled: DATA_WIDTH+1 edges
  - bypass: 1 edge
- Throughput: one result per DATA_WIDTH+2 cycles minimum with out_ready held high.
- in_ready=0 in SEARCH and DONE; in_valid there is ignored and must be held by the upstream.
- Width rules: compare is signed DATA_WIDTH; no extension needed because the target is clamped to [0, ONE].

Test Plan:
- Reset mid-SEARCH (cycle 10 after accept) → next edge out_valid=0, out_x=0, in_ready=1 one cycle later; a subsequent y=0x00200000 completes normally.
- y=0x00200000 (0.5), enable=1 → out_valid exactly 33 edges after accept; sigmoid_pwl(out_x) <= 0x00200000 < sigmoid_pwl(out_x+1); flags 0.
- Sweep 256 random y in [0, 0x00400000] → each result matches the golden bisection model bit-exactly, and the bracketing property holds.
- y=0x00400000 (1.0) → out_x=0x7FFFFFFF, out_sat_hi=1. y=0x80000000 (negative) → clamped to 0; result equals the y=0 case.
- enable=0, y=0x12345678 → out_x=0x12345678 one edge after accept, flags 0.
- out_ready held low 5 cycles in DONE → out_x and flags stable and in_ready=0 throughout; out_ready=1 → IDLE next edge, in_ready=1.
